// File: rtl/fifo_tester_gen.sv
// Traffic generator and checker for a FIFO under test. An LFSR data stream is written
// at a random rate, popped at a random rate, and compared against a replica stream.
module fifo_tester_gen #(
    parameter int          DW    = 16,
    parameter int          DEPTH = 8192,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic [31:0]   num_trans_i,
    input  logic [7:0]    wr_rate_i,
    input  logic [7:0]    rd_rate_i,
    output logic          wr_en_o,
    output logic [DW-1:0] wr_data_o,
    input  logic          full_i,
    output logic          rd_en_o,
    input  logic [DW-1:0] rd_data_i,
    input  logic          empty_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   errors_o,
    output logic          pass_o
);
    localparam int            OW      = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [15:0] WR_TAPS = 16'hB400;
    localparam logic [15:0] RD_TAPS = 16'hD008;

    function automatic logic [DW-1:0] data_taps();
        case (DW)
            8:       return DW'(8'hB8);
            16:      return DW'(16'hB400);
            32:      return DW'(32'hA300_0000);
            64:      return DW'(64'hD800_0000_0000_0000);
            default: return DW'(3) << (DW - 2);
        endcase
    endfunction

    localparam logic [DW-1:0] DATA_TAPS = data_taps();
    localparam logic [DW-1:0] SEED_X    = DW'(SEED);
    localparam logic [DW-1:0] DATA_SEED = (SEED_X == '0) ? DW'(1) : SEED_X;
    localparam logic [15:0]   RATE_SEED = (SEED == 16'h0) ? 16'h0001 : SEED;

    // Right-shifting Galois form with the top tap set: a non-zero state never reaches zero.
    function automatic logic [15:0] step16(input logic [15:0] v, input logic [15:0] taps);
        return (v >> 1) ^ (v[0] ? taps : 16'h0000);
    endfunction

    function automatic logic [DW-1:0] step_data(input logic [DW-1:0] v);
        return (v >> 1) ^ (v[0] ? DATA_TAPS : '0);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [31:0]   num_q, num_d;
    logic [31:0]   wr_cnt_q, wr_cnt_d;
    logic [31:0]   rd_cnt_q, rd_cnt_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [15:0]   errors_q, errors_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] ref_q, ref_d;
    logic [15:0]   wr_lfsr_q, wr_lfsr_d;
    logic [15:0]   rd_lfsr_q, rd_lfsr_d;

    logic        run;
    logic        wr_acc;
    logic        rd_acc;
    logic        mismatch;
    logic        overflow;
    logic [16:0] err_sum;

    assign run      = (state_q == S_RUN);
    assign wr_en_o  = run && (wr_lfsr_q[7:0] < wr_rate_i) && (wr_cnt_q < num_q);
    assign rd_en_o  = run && (rd_lfsr_q[7:0] < rd_rate_i) && (rd_cnt_q < num_q);
    assign wr_acc   = wr_en_o && !full_i;
    assign rd_acc   = rd_en_o && !empty_i;
    assign mismatch = rd_acc && (rd_data_i != ref_q);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d   = state_q;
        num_d     = num_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        occ_d     = occ_q;
        errors_d  = errors_q;
        data_d    = data_q;
        ref_d     = ref_q;
        wr_lfsr_d = wr_lfsr_q;
        rd_lfsr_d = rd_lfsr_q;
        overflow  = 1'b0;
        err_sum   = '0;

        if (run) begin
            wr_lfsr_d = step16(wr_lfsr_q, WR_TAPS);
            rd_lfsr_d = step16(rd_lfsr_q, RD_TAPS);
            if (wr_acc) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
                data_d   = step_data(data_q);
            end
            if (rd_acc) begin
                rd_cnt_d = rd_cnt_q + 32'd1;
                ref_d    = step_data(ref_q);
            end
            // Occupancy clamps at its limits; a write past DEPTH is reported, not stored.
            if (wr_acc && !rd_acc) begin
                if (occ_q >= DEPTH_W) overflow = 1'b1;
                else                  occ_d    = occ_q + OW'(1);
            end else if (rd_acc && !wr_acc && (occ_q != '0)) begin
                occ_d = occ_q - OW'(1);
            end
            err_sum  = {1'b0, errors_q} + 17'(mismatch) + 17'(overflow);
            errors_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if ((wr_cnt_d == num_q) && (rd_cnt_d == num_q)) state_d = S_DONE;
        end else if (start_i) begin
            num_d     = num_trans_i;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            occ_d     = '0;
            errors_d  = '0;
            data_d    = DATA_SEED;
            ref_d     = DATA_SEED;
            wr_lfsr_d = RATE_SEED;
            rd_lfsr_d = RATE_SEED;
            state_d   = (num_trans_i == 32'd0) ? S_DONE : S_RUN;
        end
    end

    // NOTE: sequential state is assigned with non-blocking <= only; reset is sampled at the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            occ_q     <= '0;
            errors_q  <= '0;
            data_q    <= DATA_SEED;
            ref_q     <= DATA_SEED;
            wr_lfsr_q <= RATE_SEED;
            rd_lfsr_q <= RATE_SEED;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            occ_q     <= occ_d;
            errors_q  <= errors_d;
            data_q    <= data_d;
            ref_q     <= ref_d;
            wr_lfsr_q <= wr_lfsr_d;
            rd_lfsr_q <= rd_lfsr_d;
        end
    end

    // Write data is blanked in IDLE so a freshly reset block drives all-zero outputs.
    assign wr_data_o = (state_q == S_IDLE) ? '0 : data_q;
    assign busy_o    = run;
    assign done_o    = (state_q == S_DONE);
    assign errors_o  = errors_q;
    assign pass_o    = done_o && (errors_q == 16'h0000);

endmodule

// File: tb/tb_fifo_tester_gen.sv
// Bench for fifo_tester_gen: an ideal first-word-fall-through FIFO model with optional
// single-word corruption or drop, driven through directed scenarios.
module tb_fifo_tester_gen;
    localparam int            DW    = 16;
    localparam int            DEPTH = 64;
    localparam logic [15:0]   SEED  = 16'hACE1;
    localparam logic [DW-1:0] BIT0  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   num_trans = '0;
    logic [7:0]    wr_rate = '0;
    logic [7:0]    rd_rate = '0;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          busy;
    logic          done;
    logic [15:0]   errors;
    logic          pass;

    always #5 clk = ~clk;

    fifo_tester_gen #(.DW(DW), .DEPTH(DEPTH), .SEED(SEED)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .num_trans_i(num_trans),
        .wr_rate_i  (wr_rate),
        .rd_rate_i  (rd_rate),
        .wr_en_o    (wr_en),
        .wr_data_o  (wr_data),
        .full_i     (full),
        .rd_en_o    (rd_en),
        .rd_data_i  (rd_data),
        .empty_i    (empty),
        .busy_o     (busy),
        .done_o     (done),
        .errors_o   (errors),
        .pass_o     (pass)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int corrupt_idx = -1;
    int drop_idx = -1;

    // Ideal FWFT FIFO model plus traffic statistics.
    logic [DW-1:0] mem [DEPTH];
    int cnt = 0, wp = 0, rp = 0;
    int pushes = 0, pops = 0, max_cnt = 0;
    int wr_full_hits = 0, rd_empty_hits = 0, both_hits = 0, wdata_bad = 0;
    logic [DW-1:0] exp_wdata = SEED;
    logic do_w, do_r, store;

    assign full    = (cnt >= DEPTH);
    assign empty   = (cnt == 0);
    assign rd_data = mem[rp];
    assign do_w    = wr_en && !full;
    assign do_r    = rd_en && !empty;
    assign store   = do_w && (pushes != drop_idx);

    // Data polynomial x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        if (!rst_n || (start && !busy)) begin
            cnt <= 0; wp <= 0; rp <= 0;
            pushes <= 0; pops <= 0; max_cnt <= 0;
            wr_full_hits <= 0; rd_empty_hits <= 0; both_hits <= 0; wdata_bad <= 0;
            exp_wdata <= SEED;
        end else begin
            if (do_w) begin
                pushes    <= pushes + 1;
                exp_wdata <= lfsr_next(exp_wdata);
                if (wr_data !== exp_wdata) wdata_bad <= wdata_bad + 1;
                if (store) begin
                    mem[wp] <= (pushes == corrupt_idx) ? (wr_data ^ BIT0) : wr_data;
                    wp      <= (wp + 1) % DEPTH;
                end
            end
            if (do_r) begin
                pops <= pops + 1;
                rp   <= (rp + 1) % DEPTH;
            end
            cnt <= cnt + int'(store) - int'(do_r);
            if (cnt > max_cnt) max_cnt <= cnt;
            if (wr_en && full)  wr_full_hits  <= wr_full_hits + 1;
            if (rd_en && empty) rd_empty_hits <= rd_empty_hits + 1;
            if (do_w && do_r)   both_hits     <= both_hits + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n, input logic [7:0] wr, input logic [7:0] rd);
        num_trans = n;
        wr_rate   = wr;
        rd_rate   = rd;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Waits for done within a cycle budget; reports the sample index where done rose,
    // the index where the model first saw all n reads, and busy around the done edge.
    task automatic wait_done(input int n, input int budget, output bit ok, output int done_at,
                             output int pops_at, output bit busy_at_done, output bit busy_before);
        bit prev_busy;
        ok = 1'b0; done_at = -1; pops_at = -1; busy_at_done = 1'b1; busy_before = 1'b0;
        prev_busy = busy;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((pops == n) && (pops_at < 0)) pops_at = i;
            if (done) begin
                ok = 1'b1; done_at = i; busy_at_done = busy; busy_before = prev_busy;
                break;
            end
            prev_busy = busy;
        end
    endtask

    task automatic test_reset();
        logic [DW+20:0] outs;
        rst_n = 1'b0;
        tick();
        tick();
        outs = {wr_en, rd_en, busy, done, pass, errors, wr_data};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_zero_trans();
        bit en_seen, done_drop;
        en_seen = 1'b0; done_drop = 1'b0;
        num_trans = 0; wr_rate = 8'd255; rd_rate = 8'd255; start = 1'b1;
        if (wr_en || rd_en) en_seen = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_done: got done=%b pass=%b busy=%b want 1 1 0", done, pass, busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_en || rd_en) en_seen = 1'b1;
            if (!done) done_drop = 1'b1;
            tick();
        end
        n_cmp++;
        if (en_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_no_enables: got %b want 0", en_seen);
        end
        n_cmp++;
        if (done_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_done_held: got drop=%b want 0", done_drop);
        end
    endtask

    task automatic test_fill_throttle();
        bit ok, b_at, b_before;
        int d_at, p_at;
        pulse_start(1000, 8'd230, 8'd26);
        wait_done(1000, 20000, ok, d_at, p_at, b_at, b_before);
        n_cmp++;
        if (ok !== 1'b1 || errors !== 16'd0 || pass !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_result: got ok=%b errors=%0d pass=%b want 1 0 1", ok, errors, pass);
        end
        n_cmp++;
        if (pushes !== 1000 || pops !== 1000) begin
            n_bad++;
            $display("FAIL fill_counts: got wr=%0d rd=%0d want 1000 1000", pushes, pops);
        end
        n_cmp++;
        if (max_cnt !== DEPTH || wr_full_hits == 0) begin
            n_bad++;
            $display("FAIL fill_throttle: got max=%0d full_hits=%0d want %0d >0", max_cnt, wr_full_hits, DEPTH);
        end
        n_cmp++;
        if (wdata_bad !== 0) begin
            n_bad++;
            $display("FAIL fill_wdata_stream: got %0d bad words want 0", wdata_bad);
        end
        n_cmp++;
        if (d_at !== p_at || b_at !== 1'b0 || b_before !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_done_timing: got done_at=%0d last_rd_at=%0d busy=%b/%b want equal 0/1",
                     d_at, p_at, b_before, b_at);
        end
    endtask

    task automatic test_drain_empty();
        bit ok, b_at, b_before;
        int d_at, p_at;
        pulse_start(1000, 8'd26, 8'd230);
        wait_done(1000, 20000, ok, d_at, p_at, b_at, b_before);
        n_cmp++;
        if (ok !== 1'b1 || errors !== 16'd0 || pass !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_result: got ok=%b errors=%0d pass=%b want 1 0 1", ok, errors, pass);
        end
        n_cmp++;
        if (rd_empty_hits == 0 || wdata_bad !== 0 || pops !== 1000) begin
            n_bad++;
            $display("FAIL drain_stats: got empty_hits=%0d bad=%0d rd=%0d want >0 0 1000",
                     rd_empty_hits, wdata_bad, pops);
        end
        n_cmp++;
        if (d_at !== p_at) begin
            n_bad++;
            $display("FAIL drain_done_timing: got done_at=%0d want %0d", d_at, p_at);
        end
    endtask

    task automatic test_corrupt_word();
        bit ok, b_at, b_before;
        int d_at, p_at;
        corrupt_idx = 100;
        pulse_start(300, 8'd128, 8'd128);
        wait_done(300, 3000, ok, d_at, p_at, b_at, b_before);
        corrupt_idx = -1;
        n_cmp++;
        if (ok !== 1'b1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL corrupt_done: got ok=%b done=%b want 1 1", ok, done);
        end
        n_cmp++;
        if (errors !== 16'd1 || pass !== 1'b0) begin
            n_bad++;
            $display("FAIL corrupt_errors: got errors=%0d pass=%b want 1 0", errors, pass);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, b_at, b_before;
        int d_at, p_at;
        pulse_start(5, 8'd255, 8'd255);
        n_cmp++;
        if (errors !== 16'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_restart: got errors=%0d busy=%b done=%b want 0 1 0", errors, busy, done);
        end
        n_cmp++;
        if (wr_data !== 16'hACE1 || wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first_word: got data=%h wr_en=%b want ace1 1", wr_data, wr_en);
        end
        tick();
        n_cmp++;
        if (wr_data !== 16'hE270) begin
            n_bad++;
            $display("FAIL b2b_second_word: got %h want e270", wr_data);
        end
        wait_done(5, 200, ok, d_at, p_at, b_at, b_before);
        n_cmp++;
        if (ok !== 1'b1 || pass !== 1'b1 || pushes !== 5 || pops !== 5) begin
            n_bad++;
            $display("FAIL b2b_result: got ok=%b pass=%b wr=%0d rd=%0d want 1 1 5 5", ok, pass, pushes, pops);
        end
        n_cmp++;
        if (both_hits == 0) begin
            n_bad++;
            $display("FAIL b2b_simultaneous: got %0d overlapping transfers want >0", both_hits);
        end
    endtask

    task automatic test_drop_word();
        bit ok, b_at, b_before;
        int d_at, p_at;
        drop_idx = 50;
        pulse_start(300, 8'd128, 8'd128);
        wait_done(300, 3000, ok, d_at, p_at, b_at, b_before);
        drop_idx = -1;
        n_cmp++;
        if (ok !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_no_done: got done_seen=%b busy=%b want 0 1", ok, busy);
        end
        n_cmp++;
        if (errors == 16'd0 || pushes !== 300) begin
            n_bad++;
            $display("FAIL drop_errors: got errors=%0d wr=%0d want >0 300", errors, pushes);
        end
    endtask

    task automatic test_reset_midrun();
        bit ok, b_at, b_before, reached, done_seen;
        int d_at, p_at;
        logic [DW+20:0] outs;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(600, 8'd200, 8'd128);
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (pushes >= 500) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (reached !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_500_writes: got wr=%0d want >=500", pushes);
        end
        rst_n = 1'b0;
        tick();
        outs = {wr_en, rd_en, busy, done, pass, errors, wr_data};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_seen = 1'b1;
        end
        n_cmp++;
        if (done_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_abort_no_done: got %b want 0", done_seen);
        end
        pulse_start(600, 8'd200, 8'd128);
        wait_done(600, 10000, ok, d_at, p_at, b_at, b_before);
        n_cmp++;
        if (ok !== 1'b1 || errors !== 16'd0 || pass !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_rerun: got ok=%b errors=%0d pass=%b want 1 0 1", ok, errors, pass);
        end
    endtask

    initial begin
        test_reset();
        test_zero_trans();
        test_fill_throttle();
        test_drain_empty();
        test_corrupt_word();
        test_back_to_back();
        test_drop_word();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
